conv_plane_loader: RTL and testbench
====================================

Name: conv_plane_loader

Overview:
- Producer end of the convolution layer's input interface.
- Accepts a byte stream (valid/ready) carrying IC binary image planes and packs them into per-channel bit vectors.
- Raises data_in_ready to the conv layer and holds planes stable until the layer reports data_out_ready, then drops data_in_ready so the layer re-arms for the next frame.

Parameters:
IC, 4, number of input channels (planes per frame)
IMG_IN_SIZE, 30, plane edge length; plane holds IMG_IN_SIZE*IMG_IN_SIZE bits
PLANE_BITS, IMG_IN_SIZE*IMG_IN_SIZE (derived), bits per plane
BYTES_PER_PLANE, ceil(PLANE_BITS/8) (derived), stream bytes per plane (113 at default)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept a byte this cycle
soft_clear  input  1  synchronous abort: discard partial frame, return to LOAD
conv_done  input  1  connected to the conv layer's data_out_ready
img_out  output  [PLANE_BITS-1:0] x IC (unpacked [0:IC-1])  packed planes to the conv layer's img_in
data_in_ready  output  1  planes complete and stable; drives the conv layer's data_in_ready
frame_done  output  1  one-cycle pulse when the conv layer finished a frame
frame_cnt  output  8  completed frames, wraps 255->0

Behaviour:
- Reset (rst_n=0, async): state=LOAD, byte_idx=0, ch_idx=0, all img_out bits 0, data_in_ready=0, frame_done=0, frame_cnt=0, in_ready=0 while rst_n low.
- States: LOAD, HOLD, RELEASE.
- LOAD:
  - in_ready=1; data_in_ready=0.
  - Byte accepted when in_valid&&in_ready.
  - Byte b of channel c writes img_out[c][b*8+k] = in_data[k] for k=0..7. LSB is the lowest bit index.
  - Bits with index >= PLANE_BITS are dropped; at default, last byte bits [7:4] are ignored.
  - Channel 0 is streamed first. byte_idx increments per accepted byte; at BYTES_PER_PLANE-1 it wraps to 0 and ch_idx increments.
  - Accepting the last byte of channel IC-1: ch_idx, byte_idx -> 0; next state HOLD. data_in_ready=1 from the following cycle, i.e. one cycle after the final handshake.
  - Planes are not cleared between frames; every in-range bit is overwritten on load.
- HOLD:
  - in_ready=0; data_in_ready=1; img_out must not change.
  - conv_done is sampled each cycle. When high: next state RELEASE; frame_done=1 for exactly the next cycle; frame_cnt+1.
- RELEASE:
  - data_in_ready=0 and in_ready=0 for exactly one cycle, guaranteeing the conv layer observes data_in_ready low and re-initialises.
  - Next state LOAD.
- soft_clear:
  - Highest priority after reset, any state. Next cycle: state=LOAD, counters 0, data_in_ready=0.
  - img_out contents and frame_cnt are retained. No frame_done pulse.
  - A byte presented in the same cycle as soft_clear is not written.
- conv_done high during LOAD or RELEASE is ignored.
- in_valid is allowed to drop between bytes at any time; no timeout.
- Register all outputs. in_ready is a registered function of state, so it is valid for the whole cycle.

Decomposition:
- Shared package (bnn_pkg): IMG_IN_SIZE/IC defaults, PLANE_BITS and BYTES_PER_PLANE derivation functions, loader state enum (LOAD, HOLD, RELEASE).
- No sub-module needed: one FSM plus a byte-to-plane write decoder, all in one module.
- The write decoder may be a generate loop per channel/byte lane.

Test Plan:
- Reset:
  - Assert rst_n=0 mid-LOAD after 50 bytes -> all img_out=0, data_in_ready=0, frame_cnt=0 immediately (async).
  - After release, in_ready=1 on first clk edge.
- Full frame load:
  - Stream 4*113 bytes, byte value = (byte_idx ^ ch)&0xFF, continuous valid -> data_in_ready rises exactly 1 cycle after the 452nd handshake.
  - img_out[2][15:8] = 0x03; bits [899:896] of each plane match low nibble of byte 112; in_ready=0 in HOLD.
- Handshake with conv layer:
  - In HOLD, hold conv_done=0 for 20 cycles -> planes stable, no frame_done.
  - Pulse conv_done=1 -> next cycle frame_done=1, data_in_ready=0; following cycle in_ready=1; frame_cnt=1.
- Stalls and back-to-back frames:
  - Random in_valid gaps (50% duty) over 3 frames, each with a conv_done response -> frame_cnt=3 and each frame's planes match the reference model.
  - conv_done asserted during LOAD -> ignored.
- soft_clear:
  - Assert after 200 bytes, with in_valid=1 in that cycle -> that byte not written; counters restart.
  - Next 452 bytes form a complete frame, bit-exact to the new data; frame_cnt unchanged by the clear.
- frame_cnt wrap: run 256 frames (shortened stream via IMG_IN_SIZE=4, IC=1, 2 bytes/plane) -> frame_cnt returns to 0 and frame_done pulses 256 times.

Source files
------------

// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared BNN parameters, size derivations and loader state encoding
package bnn_pkg;

  localparam int IC_DEF          = 4;
  localparam int IMG_IN_SIZE_DEF = 30;

  function automatic int plane_bits(input int img_size);
    return img_size * img_size;
  endfunction

  function automatic int bytes_per_plane(input int img_size);
    return (plane_bits(img_size) + 7) / 8;
  endfunction

  // Index counters need at least one bit even when only one value exists.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2
  } loader_state_e;

endpackage

// File: rtl/conv_plane_loader.sv
// rtl/conv_plane_loader.sv - byte-stream to bit-plane loader feeding the conv layer input
//
// Packs IC binary planes from a valid/ready byte stream into per-channel bit
// vectors, presents them with data_in_ready until the conv layer finishes,
// then drops data_in_ready for one cycle so the layer re-arms.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data/in_valid    stream byte and its valid
//   in_ready            loader accepts a byte this cycle (registered)
//   soft_clear          synchronous abort back to LOAD, planes and frame_cnt kept
//   conv_done           conv layer's data_out_ready
//   img_out[0:IC-1]     packed planes, bit b*8+k of channel c = bit k of byte b
//   data_in_ready       planes complete and stable
//   frame_done          one-cycle pulse per finished frame
//   frame_cnt           completed frames, wraps at 255
module conv_plane_loader
  import bnn_pkg::*;
#(
  parameter int IC              = IC_DEF,
  parameter int IMG_IN_SIZE     = IMG_IN_SIZE_DEF,
  localparam int PLANE_BITS     = plane_bits(IMG_IN_SIZE),
  localparam int BYTES_PER_PLANE = bytes_per_plane(IMG_IN_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  soft_clear,
  input  logic                  conv_done,
  output logic [PLANE_BITS-1:0] img_out [0:IC-1],
  output logic                  data_in_ready,
  output logic                  frame_done,
  output logic [7:0]            frame_cnt
);

  localparam int BW = idx_width(BYTES_PER_PLANE);
  localparam int CW = idx_width(IC);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES_PER_PLANE - 1);
  localparam logic [CW-1:0] LAST_CH   = CW'(IC - 1);

  loader_state_e state_q, state_d;
  logic [BW-1:0] byte_idx_q, byte_idx_d;
  logic [CW-1:0] ch_idx_q, ch_idx_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          frame_done_q, frame_done_d;
  logic          data_in_ready_q, data_in_ready_d;
  logic          in_ready_q, in_ready_d;
  logic          wr_en;
  logic [PLANE_BITS-1:0] img_q [0:IC-1];

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    ch_idx_d     = ch_idx_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    wr_en        = 1'b0;

    if (soft_clear) begin
      // Abort wins over any handshake in the same cycle, so no byte is written.
      state_d    = ST_LOAD;
      byte_idx_d = '0;
      ch_idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          if (in_valid && in_ready_q) begin
            wr_en = 1'b1;
            if (byte_idx_q == LAST_BYTE) begin
              byte_idx_d = '0;
              if (ch_idx_q == LAST_CH) begin
                ch_idx_d = '0;
                state_d  = ST_HOLD;
              end else begin
                ch_idx_d = ch_idx_q + 1'b1;
              end
            end else begin
              byte_idx_d = byte_idx_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (conv_done) begin
            state_d      = ST_RELEASE;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 8'd1;
          end
        end
        ST_RELEASE: state_d = ST_LOAD;
        default:    state_d = ST_LOAD;
      endcase
    end

    // Handshake outputs are registered copies of the next state.
    in_ready_d      = (state_d == ST_LOAD);
    data_in_ready_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_LOAD;
      byte_idx_q      <= '0;
      ch_idx_q        <= '0;
      frame_cnt_q     <= '0;
      frame_done_q    <= 1'b0;
      data_in_ready_q <= 1'b0;
      in_ready_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      byte_idx_q      <= byte_idx_d;
      ch_idx_q        <= ch_idx_d;
      frame_cnt_q     <= frame_cnt_d;
      frame_done_q    <= frame_done_d;
      data_in_ready_q <= data_in_ready_d;
      in_ready_q      <= in_ready_d;
    end
  end

  // Write decoder: one byte lane per channel/byte slot. The last lane of a
  // plane is narrower when PLANE_BITS is not a multiple of 8; the surplus
  // high bits of that stream byte are dropped.
  for (genvar c = 0; c < IC; c++) begin : g_ch
    for (genvar b = 0; b < BYTES_PER_PLANE; b++) begin : g_byte
      localparam int LO = b * 8;
      localparam int W  = ((PLANE_BITS - LO) < 8) ? (PLANE_BITS - LO) : 8;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          img_q[c][LO +: W] <= '0;
        end else if (wr_en && (ch_idx_q == CW'(c)) && (byte_idx_q == BW'(b))) begin
          img_q[c][LO +: W] <= in_data[W-1:0];
        end
      end
    end
  end

  assign img_out       = img_q;
  assign in_ready      = in_ready_q;
  assign data_in_ready = data_in_ready_q;
  assign frame_done    = frame_done_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_conv_plane_loader.sv
// tb/tb_conv_plane_loader.sv - self-checking bench for conv_plane_loader
module tb_conv_plane_loader;

  localparam int IC    = 4;
  localparam int IMG   = 30;
  localparam int PB    = IMG * IMG;
  localparam int BPP   = (PB + 7) / 8;
  localparam int S_IMG = 4;
  localparam int S_PB  = S_IMG * S_IMG;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid, soft_clear, conv_done;
  logic          in_ready, data_in_ready, frame_done;
  logic [7:0]    frame_cnt;
  logic [PB-1:0] img_out [0:IC-1];

  logic [7:0]      s_in_data;
  logic            s_in_valid, s_soft_clear, s_conv_done;
  logic            s_in_ready, s_data_in_ready, s_frame_done;
  logic [7:0]      s_frame_cnt;
  logic [S_PB-1:0] s_img_out [0:0];

  conv_plane_loader #(.IC(IC), .IMG_IN_SIZE(IMG)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .soft_clear(soft_clear), .conv_done(conv_done),
    .img_out(img_out), .data_in_ready(data_in_ready), .frame_done(frame_done),
    .frame_cnt(frame_cnt)
  );

  conv_plane_loader #(.IC(1), .IMG_IN_SIZE(S_IMG)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_data(s_in_data), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .soft_clear(s_soft_clear), .conv_done(s_conv_done),
    .img_out(s_img_out), .data_in_ready(s_data_in_ready), .frame_done(s_frame_done),
    .frame_cnt(s_frame_cnt)
  );

  int vectors = 0;
  int miscompares = 0;
  int exp_cnt = 0;
  int s_pulses = 0;

  logic [PB-1:0]    ref_p [0:IC-1];
  logic [IC*PB-1:0] exp_q [$];
  logic [IC*PB-1:0] last_exp;
  logic [S_PB-1:0]  s_ref;

  always @(negedge clk) if (s_frame_done === 1'b1) s_pulses++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_plane(input string tag, input logic [PB-1:0] obs, input logic [PB-1:0] exp);
    int d;
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      d = -1;
      for (int i = PB - 1; i >= 0; i--) if (obs[i] !== exp[i]) d = i;
      $error("FAIL %s: first differing bit %0d observed %b expected %b (low word observed %h expected %h)",
             tag, d, obs[d], exp[d], obs[63:0], exp[63:0]);
    end
  endtask

  task automatic model_wr(input int c, input int b, input logic [7:0] v);
    if (b == BPP - 1) ref_p[c][PB-1 -: 4] = v[3:0];
    else              ref_p[c][b*8 +: 8] = v;
  endtask

  function automatic logic [IC*PB-1:0] flat_ref();
    logic [IC*PB-1:0] f;
    for (int c = 0; c < IC; c++) f[c*PB +: PB] = ref_p[c];
    return f;
  endfunction

  task automatic send_byte(input int c, input int b, input logic [7:0] v, input int gap,
                           input bit rand_cd, input bit last);
    repeat (gap) begin
      in_valid = 1'b0;
      if (rand_cd) conv_done = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b1;
    in_data  = v;
    if (rand_cd) conv_done = 1'($urandom_range(0, 1));
    chk("in_ready_load", 32'(in_ready), 32'd1);
    if (last) chk("dir_before_last", 32'(data_in_ready), 32'd0);
    step();
    in_valid  = 1'b0;
    conv_done = 1'b0;
    model_wr(c, b, v);
  endtask

  task automatic check_planes();
    logic [IC*PB-1:0] e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      for (int c = 0; c < IC; c++) chk_plane($sformatf("plane%0d", c), img_out[c], e[c*PB +: PB]);
    end
  endtask

  task automatic send_frame(input bit rnd, input bit gaps, input bit rand_cd);
    logic [7:0] v;
    for (int c = 0; c < IC; c++) begin
      for (int b = 0; b < BPP; b++) begin
        v = rnd ? 8'($urandom) : 8'(b ^ c);
        send_byte(c, b, v, gaps ? int'($urandom_range(0, 1)) : 0, rand_cd,
                  (c == IC - 1) && (b == BPP - 1));
      end
    end
    last_exp = flat_ref();
    exp_q.push_back(last_exp);
    chk("dir_after_last", 32'(data_in_ready), 32'd1);
    chk("in_ready_hold", 32'(in_ready), 32'd0);
    chk("frame_done_hold", 32'(frame_done), 32'd0);
    chk("frame_cnt_after_load", 32'(frame_cnt), 32'(exp_cnt));
    check_planes();
  endtask

  task automatic release_frame();
    conv_done = 1'b1;
    step();
    conv_done = 1'b0;
    exp_cnt = (exp_cnt + 1) & 255;
    chk("frame_done_pulse", 32'(frame_done), 32'd1);
    chk("dir_release", 32'(data_in_ready), 32'd0);
    chk("in_ready_release", 32'(in_ready), 32'd0);
    chk("frame_cnt_inc", 32'(frame_cnt), 32'(exp_cnt));
    step();
    chk("frame_done_end", 32'(frame_done), 32'd0);
    chk("in_ready_reload", 32'(in_ready), 32'd1);
    chk("dir_reload", 32'(data_in_ready), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; soft_clear = 1'b0; conv_done = 1'b0;
    s_in_data = 8'h00; s_in_valid = 1'b0; s_soft_clear = 1'b0; s_conv_done = 1'b0;
    s_ref = '0;
    for (int c = 0; c < IC; c++) ref_p[c] = '0;

    // Reset state
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_dir", 32'(data_in_ready), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk_plane("rst_plane0", img_out[0], '0);
    step();
    chk("rst_in_ready_held", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    step();
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Asynchronous reset in the middle of a load
    for (int n = 0; n < 50; n++) send_byte(n / BPP, n % BPP, 8'($urandom), 0, 1'b0, 1'b0);
    chk_plane("partial_plane0", img_out[0], ref_p[0]);
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < IC; c++) ref_p[c] = '0;
    chk_plane("async_rst_plane0", img_out[0], ref_p[0]);
    chk("async_rst_in_ready", 32'(in_ready), 32'd0);
    chk("async_rst_dir", 32'(data_in_ready), 32'd0);
    chk("async_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    step();
    chk("in_ready_after_rst2", 32'(in_ready), 32'd1);

    // Full frame with the (byte ^ channel) pattern, continuous valid
    send_frame(1'b0, 1'b0, 1'b0);
    chk("img2_byte1", 32'(img_out[2][15:8]), 32'h03);
    for (int c = 0; c < IC; c++)
      chk($sformatf("tail_nibble_ch%0d", c), 32'(img_out[c][899:896]), 32'((112 ^ c) & 15));

    // Hold with conv_done low: planes stable, no frame_done
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_frame_done", 32'(frame_done), 32'd0);
      chk("hold_dir", 32'(data_in_ready), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      if (i == 19)
        for (int c = 0; c < IC; c++) chk_plane("hold_stable", img_out[c], last_exp[c*PB +: PB]);
    end
    release_frame();

    // Three frames with random valid gaps and conv_done noise during LOAD
    for (int f = 0; f < 3; f++) begin
      send_frame(1'b1, 1'b1, 1'b1);
      repeat ($urandom_range(0, 4)) step();
      release_frame();
    end

    // soft_clear on the 200th byte with in_valid high
    for (int n = 0; n < 199; n++) send_byte(n / BPP, n % BPP, 8'($urandom), 0, 1'b0, 1'b0);
    in_valid   = 1'b1;
    in_data    = ~ref_p[1][86*8 +: 8];
    soft_clear = 1'b1;
    step();
    in_valid   = 1'b0;
    soft_clear = 1'b0;
    chk("clr_in_ready", 32'(in_ready), 32'd1);
    chk("clr_dir", 32'(data_in_ready), 32'd0);
    chk("clr_frame_done", 32'(frame_done), 32'd0);
    chk("clr_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    for (int c = 0; c < IC; c++) chk_plane("clr_retained", img_out[c], ref_p[c]);
    send_frame(1'b1, 1'b0, 1'b0);

    // soft_clear during HOLD beats conv_done
    soft_clear = 1'b1;
    conv_done  = 1'b1;
    step();
    soft_clear = 1'b0;
    conv_done  = 1'b0;
    chk("hclr_dir", 32'(data_in_ready), 32'd0);
    chk("hclr_in_ready", 32'(in_ready), 32'd1);
    chk("hclr_frame_done", 32'(frame_done), 32'd0);
    chk("hclr_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    chk_plane("hclr_plane3", img_out[3], last_exp[3*PB +: PB]);

    // frame_cnt wrap on the reduced instance: 256 two-byte frames
    for (int f = 0; f < 256; f++) begin
      for (int b = 0; b < 2; b++) begin
        s_in_valid = 1'b1;
        s_in_data  = 8'($urandom);
        s_ref[b*8 +: 8] = s_in_data;
        step();
      end
      s_in_valid = 1'b0;
      if (f % 64 == 0) begin
        chk("s_dir", 32'(s_data_in_ready), 32'd1);
        chk("s_plane", 32'(s_img_out[0]), 32'(s_ref));
      end
      s_conv_done = 1'b1;
      step();
      s_conv_done = 1'b0;
      if (f == 254) chk("s_frame_cnt_255", 32'(s_frame_cnt), 32'd255);
      step();
    end
    chk("s_frame_cnt_wrap", 32'(s_frame_cnt), 32'd0);
    chk("s_frame_done_pulses", 32'(s_pulses), 32'd256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
